// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed 3-bit -> seven-segment scan controller with dead-time blanking.
// Optional leading-zero suppression is compiled in when SEG7_LEADING_BLANK_EN is defined.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  wr_en,
  input  logic [2:0]            wr_idx,
  input  logic [2:0]            wr_data,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] dig_en,
  output logic                  frame_done
);

  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int CNT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam bit               HAS_BLANK  = (BLANK_CYCLES > 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    BLANK = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2:0]            digit_q [NUM_DIGITS];
  logic [2:0]            shadow_q, shadow_d;
  logic                  blank_q, blank_d;
  logic                  lead_d;
  logic                  start_dwell;
  logic                  frame_d;
  logic [6:0]            seg_d;
  logic [NUM_DIGITS-1:0] dig_en_d;

  function automatic logic [6:0] decode(input logic [2:0] v);
    case (v)
      3'd0:    decode = 7'h7E;
      3'd1:    decode = 7'h30;
      3'd2:    decode = 7'h6D;
      3'd3:    decode = 7'h79;
      3'd4:    decode = 7'h33;
      3'd5:    decode = 7'h5B;
      3'd6:    decode = 7'h5F;
      default: decode = 7'h70;
    endcase
  endfunction

  // Scan sequencer: one shared counter times both the dwell and the dead-time gap.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    start_dwell = 1'b0;
    frame_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d     = DWELL;
          idx_d       = '0;
          cnt_d       = '0;
          start_dwell = 1'b1;
        end
      end
      DWELL: begin
        if (cnt_q == DWELL_LAST) begin
          idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
          cnt_d   = '0;
          frame_d = (idx_q == LAST_IDX);
          if (HAS_BLANK) begin
            state_d = BLANK;
          end else begin
            start_dwell = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d     = DWELL;
          cnt_d       = '0;
          start_dwell = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase

    if (!enable) begin
      state_d     = IDLE;
      idx_d       = '0;
      cnt_d       = '0;
      start_dwell = 1'b0;
      frame_d     = 1'b0;
    end
  end

`ifdef SEG7_LEADING_BLANK_EN
  // Blank the digit about to be lit when it and every more-significant digit hold zero.
  always_comb begin
    lead_d = (idx_d != '0);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((IDX_W'(i) >= idx_d) && (digit_q[i] != 3'd0)) lead_d = 1'b0;
    end
  end
`else
  assign lead_d = 1'b0;
`endif

  // Shadow value is captured from the pre-write register file, so a same-cycle write waits a visit.
  always_comb begin
    shadow_d = shadow_q;
    blank_d  = blank_q;
    if (start_dwell) begin
      shadow_d = digit_q[idx_d];
      blank_d  = lead_d;
    end

    seg_d    = '0;
    dig_en_d = '0;
    if (state_d == DWELL) begin
      dig_en_d = NUM_DIGITS'(1) << idx_d;
      if (!blank_d) seg_d = decode(shadow_d);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the digit register file is reset too, since every digit must read 0 after reset.
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (wr_idx == 3'(i)) digit_q[i] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      shadow_q   <= '0;
      blank_q    <= 1'b0;
      seg        <= '0;
      dig_en     <= '0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      shadow_q   <= shadow_d;
      blank_q    <= blank_d;
      seg        <= seg_d;
      dig_en     <= dig_en_d;
      frame_done <= frame_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: two instances (with and without dead time) against a
// positional reference model; leading-blank checks are active when SEG7_LEADING_BLANK_EN is defined.
module tb_seg7_scan_ctrl;

  localparam int N = 4;
  localparam int P = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_idx = '0;
  logic [2:0] wr_data = '0;

  logic [6:0]   seg, seg_ng;
  logic [N-1:0] dig_en, dig_en_ng;
  logic         frame_done, frame_done_ng;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.NUM_DIGITS(N), .PRESCALE(P), .BLANK_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_data(wr_data), .seg(seg), .dig_en(dig_en), .frame_done(frame_done)
  );

  seg7_scan_ctrl #(.NUM_DIGITS(N), .PRESCALE(P), .BLANK_CYCLES(0)) dut_ng (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_data(wr_data), .seg(seg_ng), .dig_en(dig_en_ng), .frame_done(frame_done_ng)
  );

  // Reference model: pos counts cycles since digit 0's first dwell began (-1 = dark).
  logic [6:0] seg_tab [8] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70};
  int         pos = -1;
  logic [2:0] mregs [N];
  logic [2:0] snap [2];
  logic       sblank [2];

  function automatic int period(int u);
    return P + ((u == 0) ? 1 : 0);
  endfunction

  function automatic logic lead_zero(int d);
    logic z;
    z = 1'b0;
`ifdef SEG7_LEADING_BLANK_EN
    z = (d != 0);
    for (int j = d; j < N; j++) if (mregs[j] != 3'd0) z = 1'b0;
`endif
    return z;
  endfunction

  task automatic model_edge();
    int per, k;
    if (!rst_n) begin
      pos = -1;
      for (int i = 0; i < N; i++) mregs[i] = '0;
    end else begin
      pos = enable ? pos + 1 : -1;
      if (pos >= 0) begin
        for (int u = 0; u < 2; u++) begin
          per = period(u);
          k   = pos % (N * per);
          if (k % per == 0) begin
            snap[u]   = mregs[k / per];
            sblank[u] = lead_zero(k / per);
          end
        end
      end
      if (wr_en && int'(wr_idx) < N) mregs[wr_idx] = wr_data;
    end
  endtask

  function automatic logic [11:0] expv(int u);
    int per, k, first;
    logic [3:0] d;
    logic [6:0] s;
    logic       f;
    per = period(u);
    d = '0; s = '0; f = 1'b0;
    if (pos >= 0) begin
      k = pos % (N * per);
      if (k % per < P) begin
        d = 4'(1 << (k / per));
        if (!sblank[u]) s = seg_tab[snap[u]];
      end
      first = (N - 1) * per + P;
      f = (pos >= first) && ((pos - first) % (N * per) == 0);
    end
    return {f, d, s};
  endfunction

  function automatic logic [11:0] got(int u);
    return (u == 0) ? {frame_done, dig_en, seg} : {frame_done_ng, dig_en_ng, seg_ng};
  endfunction

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int idx, input int data);
    wr_en = 1'b1; wr_idx = 3'(idx); wr_data = 3'(data);
    cycle();
    wr_en = 1'b0;
  endtask

  task automatic restart();
    enable = 1'b0;
    cycle();
    enable = 1'b1;
    cycle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      cycle();
      for (int u = 0; u < 2; u++) begin
        checks++;
        if (got(u) !== 12'h000) begin
          errors++;
          $display("FAIL reset_hold u=%0d c=%0d got=%h exp=000", u, c, got(u));
        end
      end
    end
  endtask

  task automatic test_scan_order();
    int fd_cnt;
    for (int i = 0; i < N; i++) do_write(i, i + 1);
    enable = 1'b1;
    cycle();
    checks++;
    if (got(0) !== {1'b0, 4'b0001, 7'h30}) begin
      errors++;
      $display("FAIL scan_first got=%h exp=%h", got(0), {1'b0, 4'b0001, 7'h30});
    end
    fd_cnt = int'(frame_done);
    for (int c = 1; c < 40; c++) begin
      cycle();
      fd_cnt += int'(frame_done);
      checks++;
      if (got(0) !== expv(0)) begin
        errors++;
        $display("FAIL scan_order pos=%0d got=%h exp=%h", pos, got(0), expv(0));
      end
    end
    checks++;
    if (fd_cnt != 2) begin
      errors++;
      $display("FAIL scan_frame_count got=%0d exp=2", fd_cnt);
    end
  endtask

  task automatic test_shadow();
    restart();
    for (int c = 0; c < 35; c++) begin
      wr_en   = (pos == 5) || (pos == 9);
      wr_idx  = (pos == 5) ? 3'd1 : 3'd2;
      wr_data = (pos == 5) ? 3'd7 : 3'd6;
      cycle();
      checks++;
      if (got(0) !== expv(0)) begin
        errors++;
        $display("FAIL shadow pos=%0d got=%h exp=%h", pos, got(0), expv(0));
      end
      if (pos == 8 || pos == 10 || pos == 25 || pos == 30) begin
        checks++;
        if (seg !== ((pos == 8) ? 7'h6D : (pos == 10) ? 7'h79 : (pos == 25) ? 7'h70 : 7'h5F)) begin
          errors++;
          $display("FAIL shadow_fixed pos=%0d got=%h", pos, seg);
        end
      end
    end
    wr_en = 1'b0;
  endtask

  task automatic test_no_gap();
    int fd_cnt;
    fd_cnt = 0;
    restart();
    fd_cnt += int'(frame_done_ng);
    for (int c = 1; c < 40; c++) begin
      cycle();
      fd_cnt += int'(frame_done_ng);
      checks++;
      if (got(1) !== expv(1)) begin
        errors++;
        $display("FAIL no_gap pos=%0d got=%h exp=%h", pos, got(1), expv(1));
      end
      if (pos == 16 || pos == 32) begin
        checks++;
        if ({frame_done_ng, dig_en_ng} !== 5'b1_0001) begin
          errors++;
          $display("FAIL no_gap_frame pos=%0d got=%b exp=10001", pos, {frame_done_ng, dig_en_ng});
        end
      end
    end
    checks++;
    if (fd_cnt != 2) begin
      errors++;
      $display("FAIL no_gap_frame_count got=%0d exp=2", fd_cnt);
    end
  endtask

  task automatic test_disable();
    restart();
    while (pos < 11) cycle();
    enable = 1'b0;
    cycle();
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (got(u) !== 12'h000) begin
        errors++;
        $display("FAIL disable_dark u=%0d got=%h exp=000", u, got(u));
      end
    end
    cycle();
    cycle();
    enable = 1'b1;
    for (int c = 0; c < 6; c++) begin
      cycle();
      checks++;
      if (got(0) !== expv(0) || (c < P && dig_en !== 4'b0001)) begin
        errors++;
        $display("FAIL reenable c=%0d got=%h exp=%h", c, got(0), expv(0));
      end
    end
  endtask

  task automatic test_reset_mid();
    restart();
    cycle();
    cycle();
    rst_n = 1'b0; wr_en = 1'b1; wr_idx = 3'd0; wr_data = 3'd5;
    cycle();
    rst_n = 1'b1; wr_en = 1'b0;
    for (int c = 0; c < 20; c++) begin
      cycle();
      checks++;
      if (got(0) !== expv(0) || (dig_en != 0 && seg !== 7'h7E)) begin
        errors++;
        $display("FAIL reset_mid c=%0d got=%h exp=%h", c, got(0), expv(0));
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst_n   = ($urandom_range(0, 199) != 0);
      enable  = ($urandom_range(0, 99) < 97);
      wr_en   = ($urandom_range(0, 99) < 30);
      wr_idx  = 3'($urandom_range(0, 7));
      wr_data = 3'($urandom_range(0, 7));
      cycle();
      for (int u = 0; u < 2; u++) begin
        checks++;
        if (got(u) !== expv(u)) begin
          errors++;
          $display("FAIL random u=%0d c=%0d pos=%0d got=%h exp=%h", u, c, pos, got(u), expv(u));
        end
      end
    end
    rst_n = 1'b1; wr_en = 1'b0;
  endtask

`ifdef SEG7_LEADING_BLANK_EN
  task automatic test_leading_blank();
    rst_n = 1'b0; enable = 1'b0;
    cycle();
    rst_n = 1'b1;
    do_write(0, 5);
    enable = 1'b1;
    for (int c = 0; c < 40; c++) begin
      wr_en = (c == 7); wr_idx = 3'd5; wr_data = 3'd3;
      cycle();
      checks++;
      if (got(0) !== expv(0) || (dig_en == 4'b0001 && seg !== 7'h5B) ||
          (dig_en != 4'b0001 && seg !== 7'h00)) begin
        errors++;
        $display("FAIL leading_blank c=%0d got=%h exp=%h", c, got(0), expv(0));
      end
    end
    wr_en = 1'b0;
  endtask
`endif

  initial begin
    for (int u = 0; u < 2; u++) begin
      snap[u] = '0;
      sblank[u] = 1'b0;
    end
    test_reset();
    test_scan_order();
    test_shadow();
    test_no_gap();
    test_disable();
    test_reset_mid();
    test_random();
`ifdef SEG7_LEADING_BLANK_EN
    test_leading_blank();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Time-multiplexed controller for a bank of 3-bit-to-seven-segment digits sharing one segment bus.
- Holds one 3-bit value per digit and scans the digits in turn: it drives the shared segment lines with the decoded pattern and enables one digit at a time.
- A dead-time gap between digits suppresses ghosting.
- Sits between the value-producing logic (write port) and the physical display pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (2..8).
- PRESCALE, 1000, clock cycles each digit stays lit per visit (>=1).
- BLANK_CYCLES, 2, dead-time cycles between digits with all outputs off (>=0).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- enable  input  1  1 = scan running, 0 = display dark.
- wr_en  input  1  write strobe for the digit register file.
- wr_idx  input  3  digit index written (0 = rightmost).
- wr_data  input  3  value 0..7 written to digit wr_idx.
- seg  output  7  segment lines, active high, bit6..bit0 = A,B,C,D,E,F,G.
- dig_en  output  NUM_DIGITS  one-hot digit enable, active high.
- frame_done  output  1  one-cycle pulse after the last digit's dwell.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - seg=0, dig_en=0, frame_done=0.
  - All digit registers 0, scan index 0, dwell/blank counters 0, state IDLE.
- Decode table, value -> seg:
  - 0 -> 7E, 1 -> 30, 2 -> 6D, 3 -> 79
  - 4 -> 33, 5 -> 5B, 6 -> 5F, 7 -> 70
- Register file:
  - wr_en=1 with wr_idx<NUM_DIGITS stores wr_data at the next edge.
  - wr_idx>=NUM_DIGITS is ignored.
  - Writes are accepted in every state, including IDLE.
- Shadow latch:
  - The value shown is latched into a shadow register when a digit's DWELL begins.
  - A write to the digit currently lit appears on that digit's next visit, never mid-dwell.
  - A write in the same cycle the dwell starts is not seen until the next visit.
- States: IDLE, DWELL, BLANK.
- IDLE:
  - seg=0, dig_en=0.
  - enable=1 -> DWELL with idx=0 at the next edge.
- DWELL:
  - dig_en = one-hot(idx), seg = decode(shadow).
  - Lasts exactly PRESCALE cycles.
  - Then idx advances, wrapping NUM_DIGITS-1 -> 0.
  - Next state is BLANK if BLANK_CYCLES>0, else DWELL of the next digit with no gap.
- BLANK:
  - seg=0, dig_en=0, lasts exactly BLANK_CYCLES cycles, then DWELL.
- frame_done:
  - High for exactly one cycle: the first cycle after the DWELL of digit NUM_DIGITS-1 ends.
  - That is the first BLANK cycle, or the first DWELL cycle of digit 0 when BLANK_CYCLES=0.
- Disable:
  - enable=0 in any state -> IDLE at the next edge; outputs 0 from that edge.
  - idx and counters return to 0.
  - The register file is retained.
  - Re-enable always restarts at digit 0 with a full dwell.
- Outputs are registered.
  - dig_en and seg never show a mixed digit/pattern in the same cycle.
  - At most one dig_en bit is ever high.
- Mid-operation rst_n=0 overrides everything, including pending writes.

Optional Feature:
- Macro: SEG7_LEADING_BLANK_EN.
- Defined:
  - During DWELL, a digit is blanked (seg=0, dig_en bit still one-hot) when its latched value is 0 and every higher-index digit also holds 0 in the register file.
  - The check uses the register file contents at dwell start.
  - Digit 0 is never blanked.
  - Timing and frame_done are unchanged.
- Undefined: all digits always display their decoded value, including leading zeros.

Test Plan:
Run with NUM_DIGITS=4, PRESCALE=4, BLANK_CYCLES=1.
- Reset then hold: seg=00, dig_en=0000, frame_done=0 for 10 cycles with enable=0.
- Scan order:
  - Write digits 0..3 = 1,2,3,4, then enable=1.
  - Observe dig_en 0001 / seg 30 for 4 cycles, then 1 blank cycle, then 0010 / 6D, 0100 / 79, 1000 / 33.
  - frame_done pulses once in the blank after digit 3; the pattern repeats every 20 cycles.
- Shadow latch: write digit 1 = 7 during digit 1's dwell -> seg stays 6D until the dwell ends; next frame shows 70.
- No gap: BLANK_CYCLES=0 -> digits change back-to-back every 4 cycles; frame_done coincides with the first 0001 cycle; the frame is 16 cycles.
- Disable/reset mid-scan:
  - enable=0 during digit 2 -> outputs 0 from the next edge.
  - Re-enable -> restarts at 0001 with a full 4-cycle dwell.
  - rst_n=0 mid-dwell -> all digit values read 0 (seg=7E) after re-enable.
- Feature, SEG7_LEADING_BLANK_EN: digits = 5,0,0,0 -> digit 0 shows 5B; digits 1..3 show seg=00 with dig_en cycling. Write wr_idx=5 -> no change in display.
